// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Operand/result handshake bundle between decode and alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       s;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             zf;
    logic             cf;
    logic             nf;
    logic             vf;
    logic             err;

    modport master (
        output in_valid, s, A, B, out_ready,
        input  in_ready, out_valid, F, zf, cf, nf, vf, err
    );

    modport slave (
        input  in_valid, s, A, B, out_ready,
        output in_ready, out_valid, F, zf, cf, nf, vf, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU with flags, multi-cycle shifts and shift-add MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int         c_cw     = SHW + 1;
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_busy   = 2'd1;
    localparam logic [1:0] c_done   = 2'd2;
    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_xor = 4'd4;
    localparam logic [3:0] c_op_nta = 4'd5;
    localparam logic [3:0] c_op_ntb = 4'd6;
    localparam logic [3:0] c_op_zro = 4'd7;
    localparam logic [3:0] c_op_shl = 4'd8;
    localparam logic [3:0] c_op_shr = 4'd9;
    localparam logic [3:0] c_op_mul = 4'd10;

    logic [1:0]         r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cw-1:0]    r_cnt;
    logic               r_sh_zero;
    logic [WIDTH-1:0]   r_f;
    logic               r_zf, r_cf, r_nf, r_vf, r_err;

    logic               w_accept;
    logic [SHW-1:0]     w_amt;
    logic [c_cw-1:0]    w_steps;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_res;
    logic               w_cf, w_vf, w_err;

    assign bus.in_ready  = (r_state == c_idle) && rst_n;
    assign bus.out_valid = (r_state == c_done);
    assign bus.F         = r_f;
    assign bus.zf        = r_zf;
    assign bus.cf        = r_cf;
    assign bus.nf        = r_nf;
    assign bus.vf        = r_vf;
    assign bus.err       = r_err;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_amt    = bus.B[SHW-1:0];

    // Number of BUSY cycles; a zero-length shift still takes one cycle.
    always_comb begin
        w_steps = c_cw'(1);
        if ((bus.s == c_op_shl || bus.s == c_op_shr) && w_amt != '0)
            w_steps = {1'b0, w_amt};
        else if (bus.s == c_op_mul)
            w_steps = c_cw'(WIDTH);
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_acc  = r_acc + (r_b[0] ? r_mcand : '0);

    always_comb begin
        w_res    = '0;
        w_cf     = 1'b0;
        w_vf     = 1'b0;
        w_err    = 1'b0;
        w_a_next = r_a;
        case (r_op)
            c_op_add: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_vf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff[WIDTH-1:0];
                w_cf  = w_diff[WIDTH];
                w_vf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_op_and: w_res = r_a & r_b;
            c_op_or:  w_res = r_a | r_b;
            c_op_xor: w_res = r_a ^ r_b;
            c_op_nta: w_res = ~r_a;
            c_op_ntb: w_res = ~r_b;
            c_op_zro: w_res = '0;
            c_op_shl: begin
                w_a_next = r_a << 1;
                w_res    = r_sh_zero ? r_a : w_a_next;
                w_cf     = !r_sh_zero && r_a[WIDTH-1];
            end
            c_op_shr: begin
                w_a_next = r_a >> 1;
                w_res    = r_sh_zero ? r_a : w_a_next;
                w_cf     = !r_sh_zero && r_a[0];
            end
            c_op_mul: begin
                w_res = w_acc[WIDTH-1:0];
                w_vf  = |w_acc[2*WIDTH-1:WIDTH];
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sh_zero <= 1'b0;
            r_f       <= '0;
            r_zf      <= 1'b0;
            r_cf      <= 1'b0;
            r_nf      <= 1'b0;
            r_vf      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_op      <= bus.s;
                        r_a       <= bus.A;
                        r_b       <= bus.B;
                        r_mcand   <= {{WIDTH{1'b0}}, bus.A};
                        r_acc     <= '0;
                        r_cnt     <= w_steps;
                        r_sh_zero <= (w_amt == '0);
                        r_state   <= c_busy;
                    end
                end
                c_busy: begin
                    // Multiplier bits are consumed from r_b LSB-first.
                    r_a     <= w_a_next;
                    r_acc   <= w_acc;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt - c_cw'(1);
                    if (r_cnt == c_cw'(1)) begin
                        r_state <= c_done;
                        r_f     <= w_res;
                        r_zf    <= (w_res == '0);
                        r_nf    <= w_res[WIDTH-1];
                        r_cf    <= w_cf;
                        r_vf    <= w_vf;
                        r_err   <= w_err;
                    end
                end
                c_done: begin
                    if (bus.out_ready)
                        r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed plus random checks of alu_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {zf, cf, nf, vf, err}.
    function automatic void model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] f, output logic [4:0] fl, output int lat);
        int ia = int'(a);
        int ib = int'(b);
        int n  = ib % 8;
        int sa = (ia > 127) ? ia - 256 : ia;
        int sb = (ib > 127) ? ib - 256 : ib;
        int r  = 0;
        logic c = 1'b0, v = 1'b0, e = 1'b0;
        lat = 1;
        case (s)
            4'd0: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ia - ib; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            4'd5: r = ~ia;
            4'd6: r = ~ib;
            4'd7: r = 0;
            4'd8: begin
                r = ia << n;
                c = (n != 0) && (((ia >> (8 - n)) & 1) == 1);
                lat = (n == 0) ? 1 : n;
            end
            4'd9: begin
                r = ia >> n;
                c = (n != 0) && (((ia >> (n - 1)) & 1) == 1);
                lat = (n == 0) ? 1 : n;
            end
            4'd10: begin r = ia * ib; v = (r > 255); lat = 8; end
            default: e = 1'b1;
        endcase
        f  = r[7:0];
        fl = {(f == 8'h00), c, f[7], v, e};
    endfunction

    task automatic start(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        int i = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s = s;
        bus.A = a;
        bus.B = b;
        while (!bus.in_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (i >= 50) chk("accept_timeout", 32'(i), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] ef;
        logic [4:0] efl;
        int el;
        int lat = 0;
        model(s, a, b, ef, efl, el);
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        chk($sformatf("latency op%0d", s), 32'(lat), 32'(el));
        chk($sformatf("F op%0d %h,%h", s, a, b), 32'(bus.F), 32'(ef));
        chk($sformatf("flags op%0d %h,%h", s, a, b),
            32'({bus.zf, bus.cf, bus.nf, bus.vf, bus.err}), 32'(efl));
    endtask

    task automatic release_result(input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        start(s, a, b);
        collect(s, a, b);
        release_result(0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rs;
        logic [7:0] held_f;
        logic [4:0] held_fl;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.s = 4'd0;
        bus.A = 8'h00;
        bus.B = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset F/flags", 32'({bus.F, bus.zf, bus.cf, bus.nf, bus.vf, bus.err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0, 8'hFF, 8'h01);
        run_op(4'd1, 8'h80, 8'h01);
        run_op(4'd10, 8'h0F, 8'h11);
        run_op(4'd10, 8'h10, 8'h10);
        run_op(4'd8, 8'h81, 8'h01);
        run_op(4'd9, 8'h81, 8'h07);
        run_op(4'd8, 8'h5A, 8'h00);
        run_op(4'd8, 8'h5A, 8'hF3);
        run_op(4'd9, 8'hC3, 8'h00);
        for (int op = 11; op < 16; op++) run_op(4'(op), 8'hFF, 8'hFF);
        run_op(4'd2, 8'hF0, 8'h3C);

        // Backpressure with a competing request waiting.
        start(4'd0, 8'h7F, 8'h01);
        collect(4'd0, 8'h7F, 8'h01);
        held_f  = bus.F;
        held_fl = {bus.zf, bus.cf, bus.nf, bus.vf, bus.err};
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s = 4'd4;
        bus.A = 8'hA5;
        bus.B = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp hold", 32'({bus.F, bus.zf, bus.cf, bus.nf, bus.vf, bus.err}),
                32'({held_f, held_fl}));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp idle out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp idle in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp accepted", 32'(bus.in_ready), 32'd0);
        collect(4'd4, 8'hA5, 8'h0F);
        release_result(0);

        // Asynchronous reset in the middle of a multiply.
        run_op(4'd0, 8'h12, 8'h34);
        start(4'd10, 8'hFF, 8'hFF);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst F/flags", 32'({bus.F, bus.zf, bus.cf, bus.nf, bus.vf, bus.err}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd0, 8'h03, 8'h04);

        for (int i = 0; i < 60; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            start(rs, ra, rb);
            collect(rs, ra, rb);
            release_result(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, sequential successor to the team's 4-bit combinational ALU. It keeps the same 8 base operations, widens the datapath to WIDTH, and adds status flags. It also adds multi-cycle shift and multiply operations that run as a small FSM. Operands enter through a valid/ready input handshake; registered results leave through a valid/ready output handshake. It sits between the decode stage and the register-file write-back.

Parameters:
WIDTH, 8, operand and result width in bits (must be ≥ 4 and a power of two)
SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept a new operation
s  input  4  opcode
A  input  WIDTH  operand A
B  input  WIDTH  operand B
out_valid  output  1  F and flags valid
out_ready  input  1  consumer accepts result
F  output  WIDTH  result
zf  output  1  zero flag
cf  output  1  carry/borrow/shift-out flag
nf  output  1  negative flag, F[WIDTH-1]
vf  output  1  overflow flag
err  output  1  illegal opcode flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, in_ready = 0 while rst_n is low.
  - out_valid, F, zf, cf, nf, vf, err = 0.
  - All internal registers are cleared; an in-flight operation is discarded.
- in_ready = 1 only in IDLE (and rst_n high). An operation is accepted on a clock edge where in_valid && in_ready; that edge latches s, A and B.
- FSM: IDLE -> BUSY on accept; BUSY -> DONE after the last step; DONE -> IDLE on the edge where out_ready = 1.
- out_valid = 1 only in DONE. F and the flags are registered and stay stable throughout DONE.
- Latency: out_valid rises k edges after the accept edge.
  - k = 1 for opcodes 0-7 and illegal opcodes.
  - k = max(1, B[SHW-1:0]) for shifts.
  - k = WIDTH for MUL.
- Throughput: one operation in flight; no new accept while BUSY or DONE. in_valid is ignored outside IDLE.
- Opcodes:
  - 0: ADD, A+B.
  - 1: SUB, A-B.
  - 2: AND.
  - 3: OR.
  - 4: XOR.
  - 5: ~A.
  - 6: ~B.
  - 7: F = 0.
  - 8: SHL, logical, A << B[SHW-1:0], one bit per BUSY cycle.
  - 9: SHR, logical, one bit per cycle.
  - 10: MUL, unsigned shift-add, one partial product per cycle; F = low WIDTH bits.
  - 11-15: illegal; F = 0, err = 1.
- Flags are computed from the final result and registered together with F:
  - zf = (F == 0).
  - nf = F[WIDTH-1].
  - cf:
    - ADD: carry-out.
    - SUB: borrow (A < B unsigned).
    - SHL/SHR: last bit shifted out; 0 if the shift amount is 0.
    - All other ops: 0.
  - vf:
    - ADD/SUB: signed two's-complement overflow.
    - MUL: 1 if the high WIDTH bits of the 2*WIDTH product are nonzero.
    - All other ops: 0.
  - err = 1 only for illegal opcodes.
- Arithmetic wraps modulo 2^WIDTH. Shift amount 0 returns F = A after 1 cycle. Bits of B above SHW are ignored for shifts.
- Backpressure: in DONE with out_ready = 0, F and the flags hold indefinitely.
- out_valid && out_ready on the same edge as a new in_valid: the new op is NOT accepted that edge. in_ready rises the cycle after the return to IDLE.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values; the op is lost. The first accept is possible on the first edge after rst_n deasserts.

Test Plan:
- WIDTH=8, ADD A=FF B=01 -> F=00, zf=1, cf=1, vf=0. out_valid 1 edge after accept. SUB A=80 B=01 -> F=7F, vf=1, nf=0, cf=0.
- MUL A=0F B=11 -> F=FF, vf=0, out_valid exactly 8 edges after accept. MUL A=10 B=10 -> F=00, zf=1, vf=1.
- SHL A=81 B=01 -> F=02, cf=1 after 1 edge. SHR A=81 B=07 -> F=01 after 7 edges. SHL B=00 -> F=A, cf=0, 1 edge. SHL B=F3 -> shift by 3 (upper bits ignored).
- Backpressure: hold out_ready=0 for 3 cycles after DONE while driving in_valid=1 with new operands. F/flags stay constant, in_ready=0, no accept. Release -> new op accepted the edge after the return to IDLE.
- Drop rst_n 3 edges into a MUL -> all outputs 0 asynchronously. After release, ADD 03+04 -> F=07 with no residue from the MUL.
- Opcodes 11-15 with A=B=FF -> F=00, err=1, zf=1, other flags 0. Following legal op -> err=0.
